left_shift_pipelined_stall: RTL and testbench

//  Pipelined logical left shifter, radix-4 (one 2-bit shift digit per stage), with

---
 rtl/left_shift_pipelined_stall_if.sv | 23 ++
 rtl/left_shift_pipelined_stall.sv | 77 +++++++
 tb/tb_left_shift_pipelined_stall.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/left_shift_pipelined_stall_if.sv
// Valid/ready stream bundle for the pipelined left shifter: operand + shift in, result out.
interface left_shift_pipelined_stall_if #(
    parameter int unsigned WIDTH   = 13,
    parameter int unsigned SHIFT_W = 4
);
    logic               inValid;
    logic               inReady;
    logic [WIDTH-1:0]   in;
    logic [SHIFT_W-1:0] shift;
    logic               outValid;
    logic               outReady;
    logic [WIDTH-1:0]   out;

    modport master (
        output inValid, in, shift, outReady,
        input  inReady, outValid, out
    );

    modport slave (
        input  inValid, in, shift, outReady,
        output inReady, outValid, out
    );
endinterface

// File: rtl/left_shift_pipelined_stall.sv
// Radix-4 pipelined logical left shifter with valid/ready flow control.
// Each stage resolves one 2-bit shift digit (MS digit first) and empty stages collapse bubbles.
module left_shift_pipelined_stall #(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned STAGES = 2
) (
    input logic                        clk,
    input logic                        resetN,
    left_shift_pipelined_stall_if.slave bus
);
    localparam int unsigned SHIFT_W = 2 * STAGES;

    logic [STAGES-1:0]  valid_q;
    logic [WIDTH-1:0]   data_q   [STAGES];
    logic [SHIFT_W-1:0] shift_q  [STAGES];

    logic [STAGES-1:0]  rdy;
    logic [STAGES-1:0]  up_valid;
    logic [WIDTH-1:0]   up_data  [STAGES];
    logic [SHIFT_W-1:0] up_shift [STAGES];
    logic [WIDTH-1:0]   nxt_data [STAGES];
    logic               rdy_acc;
    int unsigned        lsb;

    // Upstream view of each stage, per-stage digit shift and the ready chain.
    always_comb begin
        up_valid    = '0;
        rdy         = '0;
        rdy_acc     = 1'b0;
        lsb         = '0;
        up_valid[0] = bus.inValid;
        up_data[0]  = bus.in;
        up_shift[0] = bus.shift;
        for (int s = 1; s < int'(STAGES); s++) begin
            up_valid[s] = valid_q[s-1];
            up_data[s]  = data_q[s-1];
            up_shift[s] = shift_q[s-1];
        end

        // Digit for stage s sits at bit 2*(STAGES-1-s); its weight 4^(STAGES-1-s) is a shift by the same amount.
        for (int s = 0; s < int'(STAGES); s++) begin
            lsb         = 32'(2 * (int'(STAGES) - 1 - s));
            nxt_data[s] = up_data[s] << (32'(up_shift[s][lsb +: 2]) << lsb);
        end

        // A stage can load if it is empty or anything downstream of it can drain.
        for (int s = 0; s < int'(STAGES); s++) begin
            rdy_acc = bus.outReady;
            for (int j = s; j < int'(STAGES); j++) begin
                rdy_acc = rdy_acc | ~valid_q[j];
            end
            rdy[s] = rdy_acc;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_q <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                data_q[s]  <= '0;
                shift_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(STAGES); s++) begin
                if (rdy[s]) begin
                    valid_q[s] <= up_valid[s];
                    data_q[s]  <= nxt_data[s];
                    shift_q[s] <= up_shift[s];
                end
            end
        end
    end

    assign bus.inReady  = rdy[0];
    assign bus.outValid = valid_q[STAGES-1];
    assign bus.out      = data_q[STAGES-1];
endmodule

// File: tb/tb_left_shift_pipelined_stall.sv
// Randomised and directed bench for left_shift_pipelined_stall against an arithmetic scoreboard.
module tb_left_shift_pipelined_stall;
    localparam int unsigned WIDTH   = 13;
    localparam int unsigned STAGES  = 2;
    localparam int unsigned SHIFT_W = 2 * STAGES;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    left_shift_pipelined_stall_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) bus ();

    left_shift_pipelined_stall #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] val;
        int               acc;
    } beat_t;

    beat_t q[$];
    beat_t nb;
    int    checks     = 0;
    int    errors     = 0;
    int    cyc        = 0;
    bit    head_seen  = 1'b0;
    int    deliv_cnt  = 0;
    int    gaps       = 0;
    int    last_deliv = -1;
    int    lat;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: multiply by 2^shift and keep the low WIDTH bits.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input logic [SHIFT_W-1:0] s);
        logic [63:0] p;
        p = 64'(d) * (64'(1) << s);
        return WIDTH'(p % (64'(1) << WIDTH));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: occupancy-based ready rule, in-order data, minimum latency.
    always @(negedge clk) begin
        if (resetN) begin
            chk("in_ready", longint'(bus.inReady), longint'(bus.outReady || q.size() < int'(STAGES)));
            if (q.size() == 0) begin
                chk("out_valid_empty", longint'(bus.outValid), 0);
            end else if (bus.outValid) begin
                chk("out_data", longint'(bus.out), longint'(q[0].val));
                if (!head_seen) begin
                    head_seen = 1'b1;
                    lat = cyc - q[0].acc + 1;
                    chk("latency_min", longint'(lat >= int'(STAGES)), 1);
                end
                if (bus.outReady) begin
                    if (last_deliv >= 0 && cyc != last_deliv + 1) gaps++;
                    last_deliv = cyc;
                    deliv_cnt++;
                    void'(q.pop_front());
                    head_seen = 1'b0;
                end
            end
            if (bus.inValid && bus.inReady) begin
                nb.val = ref_shift(bus.in, bus.shift);
                nb.acc = cyc + 1;
                q.push_back(nb);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic [SHIFT_W-1:0] s, output int tries);
        bit taken;
        taken       = 1'b0;
        tries       = 0;
        bus.inValid = 1'b1;
        bus.in      = d;
        bus.shift   = s;
        while (!taken && tries < 50) begin
            @(negedge clk);
            taken = bus.inReady;
            tries++;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", longint'(taken), 1);
    endtask

    task automatic idle();
        bus.inValid = 1'b0;
    endtask

    task automatic wait_out(input logic [WIDTH-1:0] exp, input string name);
        int k;
        bit seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = bus.outValid;
        end
        chk({name, "_seen"}, longint'(seen), 1);
        if (seen) begin
            chk({name, "_val"}, longint'(bus.out), longint'(exp));
            chk({name, "_lat"}, longint'(k), longint'(STAGES));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while (q.size() != 0 && k < max) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", longint'(q.size()), 0);
    endtask

    initial begin
        int               t;
        int               total;
        logic [WIDTH-1:0] d[4];
        logic [SHIFT_W-1:0] s[4];
        logic [WIDTH-1:0] e0;

        bus.inValid  = 1'b0;
        bus.in       = '0;
        bus.shift    = '0;
        bus.outReady = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_outvalid", longint'(bus.outValid), 0);
        chk("reset_out", longint'(bus.out), 0);
        @(posedge clk);
        #2 resetN = 1'b1;
        @(posedge clk);
        #1;

        // Directed single beats with literal results
        bus.outReady = 1'b1;
        send(13'h0001, 4'd12, t); idle(); wait_out(13'h1000, "sh12");
        send(13'h1FFF, 4'd5,  t); idle(); wait_out(13'h1FE0, "sh5");
        send(13'h1FFF, 4'd0,  t); idle(); wait_out(13'h1FFF, "sh0");
        send(13'h1FFF, 4'd13, t); idle(); wait_out(13'h0000, "sh13");
        send(13'h1FFF, 4'd15, t); idle(); wait_out(13'h0000, "sh15");

        // Back-to-back stream of 8 beats
        deliv_cnt  = 0;
        gaps       = 0;
        last_deliv = -1;
        total      = 0;
        for (int i = 0; i < 8; i++) begin
            send(WIDTH'($urandom), SHIFT_W'(i), t);
            total += t;
        end
        idle();
        drain(30);
        chk("stream_tries", longint'(total), 8);
        chk("stream_count", longint'(deliv_cnt), 8);
        chk("stream_gaps", longint'(gaps), 0);

        // Downstream stall with 4 beats
        deliv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = WIDTH'($urandom);
            s[i] = SHIFT_W'($urandom_range(0, 12));
        end
        e0           = ref_shift(d[0], s[0]);
        bus.outReady = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(d[i], s[i], t);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_inready", longint'(bus.inReady), 0);
                chk("stall_outvalid", longint'(bus.outValid), 1);
                chk("stall_out", longint'(bus.out), longint'(e0));
                repeat (2) @(negedge clk);
                chk("stall_hold", longint'(bus.out), longint'(e0));
                chk("stall_inready_hold", longint'(bus.inReady), 0);
                @(posedge clk);
                #1 bus.outReady = 1'b1;
            end
        join
        drain(30);
        chk("stall_count", longint'(deliv_cnt), 4);

        // Bubble collapse: second beat enters while first is stalled in the last stage
        deliv_cnt    = 0;
        bus.outReady = 1'b0;
        d[0] = WIDTH'($urandom);
        s[0] = SHIFT_W'($urandom_range(0, 12));
        e0   = ref_shift(d[0], s[0]);
        send(d[0], s[0], t); idle();
        @(posedge clk);
        #1;
        send(WIDTH'($urandom), SHIFT_W'($urandom), t); idle();
        chk("bubble_tries", longint'(t), 1);
        @(negedge clk);
        chk("bubble_outvalid", longint'(bus.outValid), 1);
        chk("bubble_out", longint'(bus.out), longint'(e0));
        @(posedge clk);
        #1 bus.outReady = 1'b1;
        drain(20);
        chk("bubble_count", longint'(deliv_cnt), 2);

        // Reset with two beats in flight
        bus.outReady = 1'b0;
        send(WIDTH'($urandom), SHIFT_W'($urandom), t);
        send(WIDTH'($urandom), SHIFT_W'($urandom), t);
        idle();
        #2;
        chk("pre_rst_valid", longint'(bus.outValid), 1);
        resetN = 1'b0;
        #1;
        chk("rst_outvalid", longint'(bus.outValid), 0);
        chk("rst_out", longint'(bus.out), 0);
        q.delete();
        head_seen = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 resetN = 1'b1;
        @(posedge clk);
        #1;
        bus.outReady = 1'b1;
        d[1] = WIDTH'($urandom);
        s[1] = SHIFT_W'($urandom_range(0, 12));
        send(d[1], s[1], t); idle(); wait_out(ref_shift(d[1], s[1]), "post_rst");

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            bus.inValid  = ($urandom_range(0, 3) != 0);
            bus.in       = WIDTH'($urandom);
            bus.shift    = SHIFT_W'($urandom);
            bus.outReady = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        idle();
        bus.outReady = 1'b1;
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
